// File: rtl/control_unit.sv
// Decoder, NZCV flag register and LOAD/RUN/HALT sequencer driving the datapath controls.
// Optional CU_ILLEGAL_TRAP_EN: undecoded opcodes halt the core and raise a registered 'illegal'.
module control_unit #(
  parameter int          OPW   = 5,
  parameter logic [3:0]  BR_OP = 4'b1100
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] instr,
  input  logic        Pre_C,
  input  logic        Pre_V,
  input  logic        Pre_Z,
  input  logic        Pre_N,
  input  logic        load_req,
  input  logic        start,
  output logic        flag_HLT,
  output logic        test_normal,
  output logic        Src_Read_B,
  output logic        Src_ALU_B,
  output logic        ADC,
  output logic        SUB,
  output logic        SBB,
  output logic        JMP,
  output logic        BRANCH,
  output logic        flag_label_PC,
  output logic        flag_Rm_PC,
  output logic        flag_Rd_PC,
  output logic        data_write_en,
  output logic        RF_write_en,
  output logic        flag_mem_RF,
  output logic        flag_ALU_RF,
  output logic        flag_Rm_RF,
  output logic        flag_PC_RF,
  output logic        LHI,
  output logic        LLI,
  output logic        flag_OutR,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [3:0]  flags,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [OPW-1:0] OP_ALU  = 5'b00000;
  localparam logic [OPW-1:0] OP_LHI  = 5'b00001;
  localparam logic [OPW-1:0] OP_LLI  = 5'b00010;
  localparam logic [OPW-1:0] OP_LDR  = 5'b00011;
  localparam logic [OPW-1:0] OP_STR  = 5'b00101;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00111;
  localparam logic [OPW-1:0] OP_SUBI = 5'b01000;
  localparam logic [OPW-1:0] OP_JMP  = 5'b10000;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10001;
  localparam logic [OPW-1:0] OP_JR   = 5'b10010;
  localparam logic [OPW-1:0] OP_OUTR = 5'b11100;
  localparam logic [OPW-1:0] OP_HLT  = 5'b11111;

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic [3:0]     flags_r;
  logic [OPW-1:0] op_s;
  logic           is_br_s;
  logic           dec_upd_s;
  logic           dec_stop_s;
  logic           run_s;
`ifdef CU_ILLEGAL_TRAP_EN
  logic           dec_undef_s;
  logic           illegal_r;
`endif

  // Branch condition over the registered {N,Z,C,V}
  function automatic logic br_cond(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: br_cond = z;
      4'b0001: br_cond = !z;
      4'b0010: br_cond = c;
      4'b0011: br_cond = !c;
      4'b0100: br_cond = n;
      4'b0101: br_cond = !n;
      4'b0110: br_cond = v;
      4'b0111: br_cond = !v;
      4'b1000: br_cond = c & !z;
      4'b1001: br_cond = !c | z;
      4'b1010: br_cond = (n == v);
      4'b1011: br_cond = (n != v);
      4'b1100: br_cond = !z & (n == v);
      4'b1101: br_cond = z | (n != v);
      4'b1110: br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  endfunction

  assign op_s    = instr[15:16-OPW];
  assign is_br_s = (instr[15:12] == BR_OP);
  assign run_s   = (state_r == ST_RUN);
  assign flags   = flags_r;
  assign state   = state_r;
`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal = illegal_r;
`endif

  // Instruction class: flag-updating, and whether it stops the sequencer
  always_comb begin
    dec_upd_s  = 1'b0;
    dec_stop_s = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    dec_undef_s = 1'b0;
`endif
    if (is_br_s) begin
      dec_stop_s = 1'b0;
    end else begin
      case (op_s)
        OP_ALU, OP_ADDI, OP_SUBI: dec_upd_s = 1'b1;
        OP_HLT:                   dec_stop_s = 1'b1;
        OP_LHI, OP_LLI, OP_LDR, OP_STR,
        OP_JMP, OP_JAL, OP_JR, OP_OUTR: dec_stop_s = 1'b0;
        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
          dec_stop_s  = 1'b1;
          dec_undef_s = 1'b1;
`else
          dec_stop_s  = 1'b0;
`endif
        end
      endcase
    end
  end

  // Sequencer next state; load_req outranks start
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (start && !load_req) state_nxt_s = ST_RUN;
        else                    state_nxt_s = ST_LOAD;
      end
      ST_RUN: begin
        if (load_req)        state_nxt_s = ST_LOAD;
        else if (dec_stop_s) state_nxt_s = ST_HALT;
        else                 state_nxt_s = ST_RUN;
      end
      ST_HALT: begin
        if (load_req)   state_nxt_s = ST_LOAD;
        else if (start) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_HALT;
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_r <= ST_LOAD;
    else      state_r <= state_nxt_s;
  end

  // Architectural NZCV: captured only on flag-updating instructions in RUN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                   flags_r <= 4'b0000;
    else if (run_s && dec_upd_s) flags_r <= {Pre_N, Pre_Z, Pre_C, Pre_V};
    else                        flags_r <= flags_r;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  // Sticky trap indication, cleared when the sequencer leaves HALT
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                                                 illegal_r <= 1'b0;
    else if (run_s && dec_undef_s && state_nxt_s == ST_HALT)  illegal_r <= 1'b1;
    else if (state_r == ST_HALT && state_nxt_s != ST_HALT)    illegal_r <= 1'b0;
    else                                                      illegal_r <= illegal_r;
  end
`endif

  // Datapath controls; everything except test_normal is quiet outside RUN
  always_comb begin
    test_normal   = (state_r == ST_LOAD);
    flag_HLT      = run_s & !dec_stop_s;
    Src_Read_B    = 1'b0;
    Src_ALU_B     = 1'b0;
    ADC           = 1'b0;
    SUB           = 1'b0;
    SBB           = 1'b0;
    JMP           = 1'b0;
    BRANCH        = 1'b0;
    flag_label_PC = 1'b0;
    flag_Rm_PC    = 1'b0;
    flag_Rd_PC    = 1'b0;
    data_write_en = 1'b0;
    RF_write_en   = 1'b0;
    flag_mem_RF   = 1'b0;
    flag_ALU_RF   = 1'b0;
    flag_Rm_RF    = 1'b0;
    flag_PC_RF    = 1'b0;
    LHI           = 1'b0;
    LLI           = 1'b0;
    flag_OutR     = 1'b0;
    if (!run_s) begin
      BRANCH = 1'b0;
    end else if (is_br_s) begin
      BRANCH = br_cond(instr[11:8], flags_r);
    end else begin
      case (op_s)
        OP_ALU: begin
          ADC         = (instr[1:0] == 2'b01);
          SUB         = instr[1];
          SBB         = (instr[1:0] == 2'b11);
          flag_ALU_RF = 1'b1;
          RF_write_en = 1'b1;
        end
        OP_LHI:  begin Src_Read_B = 1'b1; LHI = 1'b1; RF_write_en = 1'b1; end
        OP_LLI:  begin LLI = 1'b1; RF_write_en = 1'b1; end
        OP_LDR:  begin Src_ALU_B = 1'b1; flag_mem_RF = 1'b1; RF_write_en = 1'b1; end
        OP_STR:  begin Src_ALU_B = 1'b1; Src_Read_B = 1'b1; data_write_en = 1'b1; end
        OP_ADDI: begin Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; end
        OP_SUBI: begin Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; SUB = 1'b1; end
        OP_JMP:  begin JMP = 1'b1; flag_label_PC = 1'b1; end
        OP_JAL:  begin JMP = 1'b1; flag_label_PC = 1'b1; flag_PC_RF = 1'b1; RF_write_en = 1'b1; end
        OP_JR:   begin JMP = 1'b1; flag_Rm_PC = 1'b1; end
        OP_OUTR: flag_OutR = 1'b1;
        default: flag_OutR = 1'b0;
      endcase
    end
  end

endmodule
